// File: rtl/stream_arbiter_hub_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_arbiter_hub_if
// Description : N-channel stb/ack producer bundle plus merged consumer stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_arbiter_hub_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
);
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_stb;
    logic [N_CH-1:0]       in_ack;
    logic [WIDTH-1:0]      out_data;
    logic [ID_W-1:0]       out_id;
    logic                  out_stb;
    logic                  out_ack;

    // Environment side: producers and the shared sink
    modport master (
        output in_data, in_stb, out_ack,
        input  in_ack, out_data, out_id, out_stb
    );

    // Hub side
    modport slave (
        input  in_data, in_stb, out_ack,
        output in_ack, out_data, out_id, out_stb
    );
endinterface
`default_nettype wire

// File: rtl/stream_arbiter_hub.sv
`default_nettype none
// ============================================================================
// Module      : stream_arbiter_hub
// Description : Round-robin merge of N_CH stb/ack streams with source tagging
//               and a sticky first-fault exception register.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_arbiter_hub #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    stream_arbiter_hub_if.slave    bus,
    input  wire logic [N_CH-1:0]   exc_in,
    input  wire logic              exc_clr,
    output logic                   exception,
    output logic [N_CH-1:0]        exc_mask,
    output logic [ID_W-1:0]        exc_first
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] c_last_rst = ID_W'(N_CH - 1);

    state_t            r_state,    w_state_nxt;
    logic [ID_W-1:0]   r_grant,    w_grant_nxt;
    logic [ID_W-1:0]   r_last,     w_last_nxt;
    logic [N_CH-1:0]   r_in_ack,   w_in_ack_nxt;
    logic [WIDTH-1:0]  r_out_data, w_out_data_nxt;
    logic [ID_W-1:0]   r_out_id,   w_out_id_nxt;
    logic              r_out_stb,  w_out_stb_nxt;

    logic              w_any_req;
    logic [ID_W-1:0]   w_winner;
    logic [N_CH-1:0]   w_winner_oh;

    logic [N_CH-1:0]   r_exc_mask, w_exc_mask_nxt;
    logic [ID_W-1:0]   r_exc_first, w_exc_first_nxt;
    logic              r_exception;
    logic [ID_W-1:0]   w_exc_low;

    // Winner = requester with the smallest rotated distance from last+1;
    // the distance is folded back once, which covers any N_CH (not just 2^k).
    always_comb begin
        int v_dist;
        int v_best;
        w_any_req   = |bus.in_stb;
        w_winner    = '0;
        w_winner_oh = '0;
        v_best      = N_CH;
        for (int k = 0; k < N_CH; k++) begin
            v_dist = k - int'(r_last) - 1;
            if (v_dist < 0) v_dist = v_dist + N_CH;
            if (bus.in_stb[k] && (v_dist < v_best)) begin
                v_best   = v_dist;
                w_winner = ID_W'(k);
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (w_winner == ID_W'(k)) w_winner_oh[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_last     <= c_last_rst;
            r_in_ack   <= '0;
            r_out_data <= '0;
            r_out_id   <= '0;
            r_out_stb  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_in_ack   <= w_in_ack_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_id   <= w_out_id_nxt;
            r_out_stb  <= w_out_stb_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_nxt     = r_last;
        w_in_ack_nxt   = '0;
        w_out_data_nxt = r_out_data;
        w_out_id_nxt   = r_out_id;
        w_out_stb_nxt  = r_out_stb;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt  = w_winner;
                    w_in_ack_nxt = w_winner_oh;
                    w_state_nxt  = S_ACK;
                end
            end
            S_ACK: begin
                // The granted producer's word transfers on this edge
                for (int k = 0; k < N_CH; k++) begin
                    if (r_grant == ID_W'(k)) w_out_data_nxt = bus.in_data[k*WIDTH +: WIDTH];
                end
                w_out_id_nxt  = r_grant;
                w_out_stb_nxt = 1'b1;
                w_last_nxt    = r_grant;
                w_state_nxt   = S_SEND;
            end
            S_SEND: begin
                if (bus.out_ack) begin
                    w_out_stb_nxt = 1'b0;
                    if (w_any_req) begin
                        w_grant_nxt  = w_winner;
                        w_in_ack_nxt = w_winner_oh;
                        w_state_nxt  = S_ACK;
                    end else begin
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Clear applies first so that same-edge sets survive and can re-capture
    always_comb begin
        w_exc_low = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (exc_in[k]) w_exc_low = ID_W'(k);
        end
        w_exc_mask_nxt  = (exc_clr ? '0 : r_exc_mask) | exc_in;
        w_exc_first_nxt = exc_clr ? '0 : r_exc_first;
        if ((exc_clr || (r_exc_mask == '0)) && (|exc_in)) w_exc_first_nxt = w_exc_low;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exc_mask  <= '0;
            r_exc_first <= '0;
            r_exception <= 1'b0;
        end else begin
            r_exc_mask  <= w_exc_mask_nxt;
            r_exc_first <= w_exc_first_nxt;
            r_exception <= |w_exc_mask_nxt;
        end
    end

    assign bus.in_ack   = r_in_ack;
    assign bus.out_data = r_out_data;
    assign bus.out_id   = r_out_id;
    assign bus.out_stb  = r_out_stb;
    assign exception    = r_exception;
    assign exc_mask     = r_exc_mask;
    assign exc_first    = r_exc_first;

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter_hub.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_arbiter_hub
// Description : Directed self-checking bench for stream_arbiter_hub (4 and 3 channels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_arbiter_hub;

    logic clk;
    logic rst;

    stream_arbiter_hub_if #(.N_CH(4), .WIDTH(32), .ID_W(2)) ifa ();
    stream_arbiter_hub_if #(.N_CH(3), .WIDTH(32), .ID_W(2)) ifb ();

    logic [3:0] exc_in_a;
    logic       exc_clr_a;
    logic       exception_a;
    logic [3:0] exc_mask_a;
    logic [1:0] exc_first_a;

    logic [2:0] exc_in_b;
    logic       exc_clr_b;
    logic       exception_b;
    logic [2:0] exc_mask_b;
    logic [1:0] exc_first_b;

    int checks;
    int failures;

    stream_arbiter_hub #(.N_CH(4), .WIDTH(32), .ID_W(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifa),
        .exc_in    (exc_in_a),
        .exc_clr   (exc_clr_a),
        .exception (exception_a),
        .exc_mask  (exc_mask_a),
        .exc_first (exc_first_a)
    );

    stream_arbiter_hub #(.N_CH(3), .WIDTH(32), .ID_W(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifb),
        .exc_in    (exc_in_b),
        .exc_clr   (exc_clr_b),
        .exception (exception_b),
        .exc_mask  (exc_mask_b),
        .exc_first (exc_first_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int e;
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        ifa.in_data = '0;
        ifa.in_stb  = '0;
        ifa.out_ack = 1'b0;
        ifb.in_data = '0;
        ifb.in_stb  = '0;
        ifb.out_ack = 1'b0;
        exc_in_a  = '0;
        exc_clr_a = 1'b0;
        exc_in_b  = '0;
        exc_clr_b = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ack",    64'(ifa.in_ack),   64'h0);
        check("rst_out_stb",   64'(ifa.out_stb),  64'h0);
        check("rst_out_data",  64'(ifa.out_data), 64'h0);
        check("rst_out_id",    64'(ifa.out_id),   64'h0);
        check("rst_exception", 64'(exception_a),  64'h0);
        check("rst_exc_mask",  64'(exc_mask_a),   64'h0);
        check("rst_exc_first", 64'(exc_first_a),  64'h0);
        rst = 1'b1;

        // Single word from channel 2
        ifa.in_data[95:64] = 32'hDEADBEEF;
        ifa.in_stb  = 4'b0100;
        ifa.out_ack = 1'b1;
        tick();
        check("single_in_ack", 64'(ifa.in_ack),  64'h4);
        check("single_stb_lo", 64'(ifa.out_stb), 64'h0);
        tick();
        ifa.in_stb = 4'b0000;
        check("single_ack_drop", 64'(ifa.in_ack),   64'h0);
        check("single_out_stb",  64'(ifa.out_stb),  64'h1);
        check("single_out_data", 64'(ifa.out_data), 64'hDEADBEEF);
        check("single_out_id",   64'(ifa.out_id),   64'h2);
        tick();
        check("single_stb_end",  64'(ifa.out_stb), 64'h0);
        check("single_no_ack1",  64'(ifa.in_ack),  64'h0);
        tick();
        check("single_no_ack2",  64'(ifa.in_ack),  64'h0);

        // Fairness: all four stream; last grant was 2, so order is 3,0,1,2,3,0
        ifa.in_data = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
        ifa.in_stb  = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            e = (3 + n) % 4;
            tick();
            check("rr_in_ack",   64'(ifa.in_ack),   64'(1 << e));
            check("rr_stb_lo",   64'(ifa.out_stb),  64'h0);
            tick();
            check("rr_out_stb",  64'(ifa.out_stb),  64'h1);
            check("rr_out_id",   64'(ifa.out_id),   64'(e));
            check("rr_out_data", 64'(ifa.out_data), 64'(32'h1000 + e));
            check("rr_ack_lo",   64'(ifa.in_ack),   64'h0);
        end

        // Backpressure while holding channel 0's word
        ifa.out_ack = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("bp_out_stb",  64'(ifa.out_stb),  64'h1);
            check("bp_out_id",   64'(ifa.out_id),   64'h0);
            check("bp_out_data", 64'(ifa.out_data), 64'h1000);
            check("bp_in_ack",   64'(ifa.in_ack),   64'h0);
        end
        ifa.out_ack = 1'b1;
        tick();
        check("bp_rel_stb", 64'(ifa.out_stb), 64'h0);
        check("bp_rel_ack", 64'(ifa.in_ack),  64'h2);
        ifa.in_stb = 4'b0010;
        tick();
        check("bp_next_id",   64'(ifa.out_id),   64'h1);
        check("bp_next_data", 64'(ifa.out_data), 64'h1001);
        ifa.in_stb = 4'b0000;
        tick();
        check("bp_idle_stb", 64'(ifa.out_stb), 64'h0);

        // Sticky exceptions
        exc_in_a = 4'b1010;
        tick();
        exc_in_a = 4'b0000;
        check("exc_mask1",  64'(exc_mask_a),  64'hA);
        check("exc_first1", 64'(exc_first_a), 64'h1);
        check("exc_flag1",  64'(exception_a), 64'h1);
        tick();
        check("exc_hold",   64'(exc_mask_a),  64'hA);
        exc_clr_a = 1'b1;
        exc_in_a  = 4'b0100;
        tick();
        exc_clr_a = 1'b0;
        exc_in_a  = 4'b0000;
        check("exc_mask2",  64'(exc_mask_a),  64'h4);
        check("exc_first2", 64'(exc_first_a), 64'h2);
        check("exc_flag2",  64'(exception_a), 64'h1);
        exc_clr_a = 1'b1;
        tick();
        exc_clr_a = 1'b0;
        check("exc_clr_mask",  64'(exc_mask_a),  64'h0);
        check("exc_clr_first", 64'(exc_first_a), 64'h0);
        check("exc_clr_flag",  64'(exception_a), 64'h0);
        exc_in_a = 4'b1000;
        tick();
        check("exc_first3", 64'(exc_first_a), 64'h3);
        exc_in_a = 4'b0001;
        tick();
        exc_in_a = 4'b0000;
        check("exc_mask4",  64'(exc_mask_a),  64'h9);
        check("exc_first4", 64'(exc_first_a), 64'h3);
        exc_clr_a = 1'b1;
        tick();
        exc_clr_a = 1'b0;

        // Async reset in the middle of SEND
        ifa.in_stb  = 4'b0001;
        ifa.out_ack = 1'b0;
        exc_in_a    = 4'b0001;
        tick();
        exc_in_a = 4'b0000;
        check("ar_in_ack", 64'(ifa.in_ack), 64'h1);
        tick();
        ifa.in_stb = 4'b0000;
        check("ar_send_stb", 64'(ifa.out_stb), 64'h1);
        check("ar_send_exc", 64'(exception_a), 64'h1);
        #3;
        rst = 1'b0;
        #1;
        check("ar_in_ack0",    64'(ifa.in_ack),   64'h0);
        check("ar_out_stb0",   64'(ifa.out_stb),  64'h0);
        check("ar_out_data0",  64'(ifa.out_data), 64'h0);
        check("ar_out_id0",    64'(ifa.out_id),   64'h0);
        check("ar_exception0", 64'(exception_a),  64'h0);
        check("ar_exc_mask0",  64'(exc_mask_a),   64'h0);
        check("ar_exc_first0", 64'(exc_first_a),  64'h0);
        #2;
        rst = 1'b1;
        ifa.in_stb  = 4'b1010;
        ifa.out_ack = 1'b1;
        tick();
        check("ar_first_ack", 64'(ifa.in_ack), 64'h2);
        tick();
        ifa.in_stb = 4'b1000;
        check("ar_first_id",   64'(ifa.out_id),   64'h1);
        check("ar_first_data", 64'(ifa.out_data), 64'h1001);
        tick();
        check("ar_second_ack", 64'(ifa.in_ack), 64'h8);
        tick();
        ifa.in_stb = 4'b0000;
        check("ar_second_id", 64'(ifa.out_id), 64'h3);
        tick();
        check("ar_end_stb", 64'(ifa.out_stb), 64'h0);

        // Three channels: wrap from 2 back to 0
        ifb.in_data = {32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
        ifb.out_ack = 1'b1;
        ifb.in_stb  = 3'b100;
        tick();
        check("n3_ack2", 64'(ifb.in_ack), 64'h4);
        tick();
        ifb.in_stb = 3'b101;
        check("n3_id2",   64'(ifb.out_id),   64'h2);
        check("n3_data2", 64'(ifb.out_data), 64'hCCCC0002);
        tick();
        check("n3_ack_wrap", 64'(ifb.in_ack), 64'h1);
        tick();
        ifb.in_stb = 3'b100;
        check("n3_id_wrap",   64'(ifb.out_id),   64'h0);
        check("n3_data_wrap", 64'(ifb.out_data), 64'hCCCC0000);
        tick();
        check("n3_ack_again", 64'(ifb.in_ack), 64'h4);
        tick();
        ifb.in_stb = 3'b000;
        check("n3_id_again", 64'(ifb.out_id), 64'h2);
        tick();
        check("n3_end_stb", 64'(ifb.out_stb), 64'h0);
        check("n3_end_ack", 64'(ifb.in_ack),  64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
